// File: rtl/legv8_instr_encoder_if.sv
// rtl/legv8_instr_encoder_if.sv - field stream and instruction-memory write bus for the LEGv8 encoder
interface legv8_instr_encoder_if #(
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [4:0]        rd;
  logic [4:0]        rn;
  logic [4:0]        rm;
  logic [18:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready;

  modport master (
    output in_valid, op, rd, rn, rm, imm, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, op, rd, rn, rm, imm, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/legv8_instr_encoder.sv
// rtl/legv8_instr_encoder.sv - packs decoded LEGv8 fields into 32-bit words and writes them to instruction memory
module legv8_instr_encoder #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  legv8_instr_encoder_if.slave     bus,
  output logic                     err,
  output logic [CNT_W-1:0]         count
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [31:0]       wdata_q, wdata_nxt;
  logic              err_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic [31:0]       enc_word;
  logic              legal;
  logic              d_in_range;
  logic              accept;

  // A D-format offset fits in 9 signed bits when bits [18:8] are all copies of bit 8.
  assign d_in_range = (bus.imm[18:8] == {11{bus.imm[8]}});

  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (bus.op)
      3'd0: enc_word = {11'b10001011000, bus.rm, 6'b000000, bus.rn, bus.rd};
      3'd1: enc_word = {11'b11001011000, bus.rm, 6'b000000, bus.rn, bus.rd};
      3'd2: enc_word = {11'b10001010000, bus.rm, 6'b000000, bus.rn, bus.rd};
      3'd3: enc_word = {11'b10101010000, bus.rm, 6'b000000, bus.rn, bus.rd};
      3'd4: begin
        enc_word = {11'b11111000010, bus.imm[8:0], 2'b00, bus.rn, bus.rd};
        legal    = d_in_range;
      end
      3'd5: begin
        enc_word = {11'b11111000000, bus.imm[8:0], 2'b00, bus.rn, bus.rd};
        legal    = d_in_range;
      end
      3'd6: enc_word = {8'b10110100, bus.imm, bus.rd};
      default: legal = 1'b0;
    endcase
  end

  // start outranks a pending field handshake; nothing is accepted while in reset.
  assign bus.in_ready   = rst_n && (state == IDLE) && !start;
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.imem_we    = (state == WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    err_nxt   = 1'b0;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (start) begin
          addr_nxt  = base_addr & ~ADDR_W'(3);
          count_nxt = '0;
        end else if (accept) begin
          if (legal) begin
            wdata_nxt = enc_word;
            state_nxt = WRITE;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      WRITE: begin
        if (bus.imem_ready) begin
          addr_nxt  = addr_q + ADDR_W'(4);
          count_nxt = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      err     <= 1'b0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      err     <= err_nxt;
      count   <= count_nxt;
    end
  end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// tb/tb_legv8_instr_encoder.sv - scoreboard bench for legv8_instr_encoder with a field-level reference model
module tb_legv8_instr_encoder;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              err;
  logic [CNT_W-1:0]  count;

  legv8_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  legv8_instr_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
  } wr_t;

  int                checks = 0;
  int                failures = 0;
  wr_t               wq[$];
  int                eq[$];
  wr_t               exp_w;
  logic [ADDR_W-1:0] m_addr = '0;
  int                m_count = 0;
  logic              auto_ready = 1'b0;
  logic              manual_ready = 1'b1;
  int                ready_pct = 100;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [31:0]       last_word = '0;
  int                last_hold = 0;
  int                hold_run = 0;
  logic              pend = 1'b0;
  logic [ADDR_W-1:0] pend_addr;
  logic [31:0]       pend_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference encoding from field weights: opcode * 2^21 etc.
  function automatic logic [31:0] ref_word(input int op, input int rd, input int rn, input int rm, input int imm);
    longint k21 = 64'd2097152;
    longint w = 0;
    longint opc = 0;
    case (op)
      0: opc = 1112;
      1: opc = 1624;
      2: opc = 1104;
      3: opc = 1360;
      4: opc = 1986;
      5: opc = 1984;
      default: opc = 0;
    endcase
    if (op <= 3)
      w = opc * k21 + longint'(rm) * 65536 + longint'(rn) * 32 + longint'(rd);
    else if (op <= 5)
      w = opc * k21 + longint'(((imm % 512) + 512) % 512) * 4096 + longint'(rn) * 32 + longint'(rd);
    else
      w = longint'(180) * 16777216 + longint'(((imm % 524288) + 524288) % 524288) * 32 + longint'(rd);
    return w[31:0];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.imem_ready = auto_ready ? ($urandom_range(1, 100) <= ready_pct) : manual_ready;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      hold_run = 0;
    end else if (bus.imem_we) begin
      hold_run++;
      if (pend) begin
        check("hold_addr", 64'(bus.imem_addr), 64'(pend_addr));
        check("hold_wdata", 64'(bus.imem_wdata), 64'(pend_word));
      end
      if (bus.imem_ready) begin
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual_addr=0x%0h actual_wdata=0x%0h required=none", bus.imem_addr, bus.imem_wdata);
        end else begin
          exp_w = wq.pop_front();
          check("wr_addr", 64'(bus.imem_addr), 64'(exp_w.addr));
          check("wr_wdata", 64'(bus.imem_wdata), 64'(exp_w.word));
        end
        last_addr = bus.imem_addr;
        last_word = bus.imem_wdata;
        last_hold = hold_run;
        hold_run = 0;
        pend = 1'b0;
      end else begin
        pend = 1'b1;
        pend_addr = bus.imem_addr;
        pend_word = bus.imem_wdata;
      end
    end else begin
      pend = 1'b0;
      hold_run = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && err) begin
      checks++;
      if (eq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_err actual=1 required=0");
      end else begin
        void'(eq.pop_front());
      end
    end
  end

  task automatic send(input int op, input int rd, input int rn, input int rm, input int imm);
    bit   ok;
    logic ill;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.op  = op[2:0];
    bus.rd  = rd[4:0];
    bus.rn  = rn[4:0];
    bus.rm  = rm[4:0];
    bus.imm = imm[18:0];
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_ready required=ready_within_200");
      bus.in_valid = 1'b0;
      return;
    end
    ill = (op == 7) || ((op == 4 || op == 5) && (imm < -256 || imm > 255));
    if (ill) begin
      eq.push_back(1);
    end else begin
      wq.push_back('{m_addr, ref_word(op, rd, rn, rm, imm)});
      m_addr = m_addr + 16'd4;
      if (m_count < 65535) m_count++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("err_pulse", 64'(err), 64'(ill));
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (wq.size() == 0 && eq.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual_pending=%0d required=0", wq.size() + eq.size());
    end
  endtask

  task automatic check_count(input string name);
    drain();
    @(negedge clk);
    check(name, 64'(count), 64'(m_count));
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b);
    drain();
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = b;
    m_addr = b & ~16'h0003;
    m_count = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, "_imem_we"}, 64'(bus.imem_we), 64'd0);
    check({tag, "_imem_addr"}, 64'(bus.imem_addr), 64'd0);
    check({tag, "_imem_wdata"}, 64'(bus.imem_wdata), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.op  = '0;
    bus.rd  = '0;
    bus.rn  = '0;
    bus.rm  = '0;
    bus.imm = '0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;

    // Basic R-format at a fresh base address
    do_start(16'h0040);
    send(0, 1, 2, 3, 0);
    check_count("count_after_add");
    check("add_word", 64'(last_word), 64'h8B030041);
    check("add_addr", 64'(last_addr), 64'h0040);

    send(4, 5, 6, 0, -8);
    drain();
    check("ldur_word", 64'(last_word), 64'hF85F80C5);
    check("ldur_addr", 64'(last_addr), 64'h0044);
    send(5, 9, 10, 0, 16);
    check_count("count_after_stur");
    check("stur_word", 64'(last_word), 64'hF8010149);
    check("stur_addr", 64'(last_addr), 64'h0048);
    check("count_three", 64'(count), 64'd3);

    // CBZ with memory back-pressure for three cycles
    manual_ready = 1'b0;
    send(6, 7, 0, 0, 4);
    check("stall_in_ready_0", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("stall_in_ready_1", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("stall_in_ready_2", 64'(bus.in_ready), 64'd0);
    manual_ready = 1'b1;
    check_count("count_after_cbz");
    check("cbz_word", 64'(last_word), 64'hB4000087);
    check("cbz_hold", 64'(last_hold), 64'd4);

    // Illegal accepts leave address and count alone
    send(4, 1, 1, 0, 300);
    send(7, 1, 1, 1, 0);
    check_count("count_after_illegal");
    send(1, 2, 3, 4, 0);
    drain();
    check("addr_after_illegal", 64'(last_addr), 64'h0050);

    // Address wrap at the top of the space
    do_start(16'hFFFE);
    send(0, 3, 4, 5, 0);
    send(0, 6, 7, 8, 0);
    check_count("count_after_wrap");
    check("wrap_addr", 64'(last_addr), 64'h0000);

    // start beats in_valid in the same cycle
    drain();
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 16'h0100;
    bus.in_valid = 1'b1;
    bus.op = 3'd0;
    @(negedge clk);
    check("start_blocks_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    m_addr = 16'h0100;
    m_count = 0;
    @(negedge clk);
    check("start_no_write", 64'(bus.imem_we), 64'd0);
    check("start_count", 64'(count), 64'd0);
    send(2, 11, 12, 13, 0);
    drain();
    check("start_reload_addr", 64'(last_addr), 64'h0100);

    // Reset while a write is pending
    manual_ready = 1'b0;
    send(3, 1, 2, 3, 0);
    check("pre_reset_we", 64'(bus.imem_we), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("midreset");
    wq.delete();
    eq.delete();
    m_addr = '0;
    m_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    manual_ready = 1'b1;

    // Randomized traffic
    auto_ready = 1'b1;
    ready_pct = 60;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_start(16'($urandom_range(0, 65535)));
      end else begin
        int op;
        int imm;
        op = $urandom_range(0, 7);
        if ($urandom_range(0, 3) == 0) imm = int'($urandom_range(0, 524287)) - 262144;
        else imm = int'($urandom_range(0, 600)) - 300;
        send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm);
      end
    end
    check_count("count_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
